// File: rtl/param_register_file.sv
// param_register_file: WIDTH x DEPTH register file with one synchronous write
// port (A), two combinational read ports (A, B) and a clear engine that zeroes
// one entry per cycle after reset or on a Clear request.
// Optional macro PARAM_REGISTER_FILE_BYPASS_EN: forward the WriteData of an
// accepted write straight to the read ports whose address matches AddressA.
module param_register_file #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic             Clear,
   input  logic [AW-1:0]    AddressA,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             WriteEnable,
   input  logic [AW-1:0]    AddressB,
   output logic [WIDTH-1:0] ReadDataA,
   output logic [WIDTH-1:0] ReadDataB,
   output logic             Ready,
   output logic [AW-1:0]    ClearIndex
);

   // AW+1 bits so a non power-of-two DEPTH compares without truncation
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

   typedef enum logic {CLEARING = 1'b0, IDLE = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [AW-1:0]     r_clear_idx, w_idx_nxt;
   logic [WIDTH-1:0]  r_mem [DEPTH];

   logic              w_a_in_range, w_b_in_range;
   logic              w_wr_acc, w_clr_we, w_mem_we;
   logic [AW-1:0]     w_mem_addr;
   logic [WIDTH-1:0]  w_mem_data;
   logic [WIDTH-1:0]  w_rd_a, w_rd_b;

   assign w_a_in_range = ({1'b0, AddressA} < DEPTH_L);
   assign w_b_in_range = ({1'b0, AddressB} < DEPTH_L);

   assign Ready      = (r_state == IDLE);
   assign ClearIndex = r_clear_idx;

   // A write is discarded when Clear wins the same edge in IDLE
   assign w_wr_acc = Ready && WriteEnable && w_a_in_range && !Clear;
   // nReset gate keeps entry 0 untouched while reset is held
   assign w_clr_we = (r_state == CLEARING) && nReset;

   assign w_mem_we   = w_clr_we || w_wr_acc;
   assign w_mem_addr = w_clr_we ? r_clear_idx : AddressA;
   assign w_mem_data = w_clr_we ? '0 : WriteData;

   // State and clear pointer; reset restarts the clear sweep from entry 0
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state     <= CLEARING;
         r_clear_idx <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_clear_idx <= w_idx_nxt;
      end
   end

   // Next state: sweep every entry once, then idle until Clear
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_clear_idx;
      case (r_state)
         CLEARING: begin
            if (r_clear_idx == LAST_IX) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_clear_idx + AW'(1);
            end
         end
         IDLE: begin
            if (Clear) begin
               w_state_nxt = CLEARING;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = CLEARING;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Storage has no reset; the clear engine zeroes it
   always_ff @(posedge Clock) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
   end

   // Stored contents, masked to 0 while clearing or when out of range
   always_comb begin
      w_rd_a = '0;
      w_rd_b = '0;
      if (Ready && w_a_in_range) w_rd_a = r_mem[AddressA];
      if (Ready && w_b_in_range) w_rd_b = r_mem[AddressB];
   end

`ifdef PARAM_REGISTER_FILE_BYPASS_EN
   // Write-through: an accepted write is visible on matching ports before the edge
   always_comb begin
      ReadDataA = w_rd_a;
      ReadDataB = w_rd_b;
      if (w_wr_acc) begin
         ReadDataA = WriteData;
         if (AddressB == AddressA) ReadDataB = WriteData;
      end
   end
`else
   // Reads always reflect stored contents only
   always_comb begin
      ReadDataA = w_rd_a;
      ReadDataB = w_rd_b;
   end
`endif

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: DEPTH=64 main instance plus a
// DEPTH=40 instance for the non power-of-two address range.
module tb_param_register_file;

   logic        Clock = 1'b0;
   logic        nReset;

   // DEPTH=64 instance
   logic        Clear, WriteEnable, Ready;
   logic [5:0]  AddressA, AddressB, ClearIndex;
   logic [15:0] WriteData, ReadDataA, ReadDataB;

   // DEPTH=40 instance
   logic        c_Clear, c_WriteEnable, c_Ready;
   logic [5:0]  c_AddressA, c_AddressB, c_ClearIndex;
   logic [15:0] c_WriteData, c_ReadDataA, c_ReadDataB;

   int tests = 0;
   int fails = 0;

   always #5 Clock = ~Clock;

   param_register_file #(.WIDTH(16), .DEPTH(64)) dut (
      .Clock(Clock), .nReset(nReset), .Clear(Clear),
      .AddressA(AddressA), .WriteData(WriteData), .WriteEnable(WriteEnable),
      .AddressB(AddressB), .ReadDataA(ReadDataA), .ReadDataB(ReadDataB),
      .Ready(Ready), .ClearIndex(ClearIndex)
   );

   param_register_file #(.WIDTH(16), .DEPTH(40)) dut40 (
      .Clock(Clock), .nReset(nReset), .Clear(c_Clear),
      .AddressA(c_AddressA), .WriteData(c_WriteData), .WriteEnable(c_WriteEnable),
      .AddressB(c_AddressB), .ReadDataA(c_ReadDataA), .ReadDataB(c_ReadDataB),
      .Ready(c_Ready), .ClearIndex(c_ClearIndex)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Step past the next rising edge; outputs settle before sampling
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      nReset = 1'b0;
      Clear = 1'b0; WriteEnable = 1'b0; AddressA = '0; AddressB = '0; WriteData = '0;
      c_Clear = 1'b0; c_WriteEnable = 1'b0; c_AddressA = '0; c_AddressB = '0; c_WriteData = '0;
      #1;
      check("rst_ready", 32'(Ready), 32'd0);
      check("rst_cidx", 32'(ClearIndex), 32'd0);
      tick(); tick();
      check("rst_hold_cidx", 32'(ClearIndex), 32'd0);
      nReset = 1'b1;

      // Power-up sweep; a write held during the sweep must be dropped
      for (int i = 0; i < 64; i++) begin
         if (i == 5) begin
            WriteEnable = 1'b1; AddressA = 6'd3; WriteData = 16'hFFFF;
         end
         check("clr_ready", 32'(Ready), 32'd0);
         check("clr_cidx", 32'(ClearIndex), 32'(i));
         check("clr_rd_zero", 32'(ReadDataA), 32'd0);
         check("d40_ready", 32'(c_Ready), (i >= 40) ? 32'd1 : 32'd0);
         check("d40_cidx", 32'(c_ClearIndex), (i < 40) ? 32'(i) : 32'd0);
         tick();
      end
      WriteEnable = 1'b0;
      check("idle_ready", 32'(Ready), 32'd1);
      check("idle_cidx", 32'(ClearIndex), 32'd0);
      AddressA = 6'd0;  AddressB = 6'd31; #1;
      check("rd0", 32'(ReadDataA), 32'h0000);
      check("rd31", 32'(ReadDataB), 32'h0000);
      AddressA = 6'd63; AddressB = 6'd3; #1;
      check("rd63", 32'(ReadDataA), 32'h0000);
      check("wr_in_clear_dropped", 32'(ReadDataB), 32'h0000);

      // Write 0xBEEF to 5; pre-edge read depends on forwarding
      AddressA = 6'd5; AddressB = 6'd5; WriteData = 16'hBEEF; WriteEnable = 1'b1; #1;
`ifdef PARAM_REGISTER_FILE_BYPASS_EN
      check("pre_edge_a", 32'(ReadDataA), 32'hBEEF);
      check("pre_edge_b", 32'(ReadDataB), 32'hBEEF);
`else
      check("pre_edge_a", 32'(ReadDataA), 32'h0000);
      check("pre_edge_b", 32'(ReadDataB), 32'h0000);
`endif
      tick();
      AddressA = 6'd63; WriteData = 16'h1234; tick();
      WriteEnable = 1'b0;
      AddressA = 6'd5; AddressB = 6'd63; #1;
      check("rdA_5", 32'(ReadDataA), 32'hBEEF);
      check("rdB_63", 32'(ReadDataB), 32'h1234);
      AddressB = 6'd5; #1;
      check("same_addr_a", 32'(ReadDataA), 32'hBEEF);
      check("same_addr_b", 32'(ReadDataB), 32'hBEEF);

      // Forwarding with AddressA == AddressB == 7
      AddressA = 6'd7; AddressB = 6'd7; WriteData = 16'h5A5A; WriteEnable = 1'b1; #1;
`ifdef PARAM_REGISTER_FILE_BYPASS_EN
      check("byp7_a", 32'(ReadDataA), 32'h5A5A);
      check("byp7_b", 32'(ReadDataB), 32'h5A5A);
`else
      check("byp7_a", 32'(ReadDataA), 32'h0000);
      check("byp7_b", 32'(ReadDataB), 32'h0000);
`endif
      tick();
      WriteEnable = 1'b0; #1;
      check("post7_b", 32'(ReadDataB), 32'h5A5A);

      // DEPTH=40: out-of-range write/read, top entry
      c_AddressA = 6'd45; c_WriteData = 16'h1111; c_WriteEnable = 1'b1; tick();
      c_AddressA = 6'd39; c_WriteData = 16'hCAFE; tick();
      c_WriteEnable = 1'b0;
      c_AddressA = 6'd45; c_AddressB = 6'd39; #1;
      check("d40_rd45", 32'(c_ReadDataA), 32'h0000);
      check("d40_rd39", 32'(c_ReadDataB), 32'hCAFE);
      c_AddressA = 6'd13; c_AddressB = 6'd5; #1;
      check("d40_alias13", 32'(c_ReadDataA), 32'h0000);
      check("d40_alias5", 32'(c_ReadDataB), 32'h0000);

      // Clear pulse with a coincident write that must be discarded
      AddressA = 6'd10; WriteData = 16'hAAAA; WriteEnable = 1'b1; tick();
      AddressA = 6'd11; WriteData = 16'h7777; Clear = 1'b1; tick();
      Clear = 1'b0; WriteEnable = 1'b0;
      for (int i = 0; i < 64; i++) begin
         Clear = (i == 30);   // ignored while clearing
         check("clr2_ready", 32'(Ready), 32'd0);
         check("clr2_cidx", 32'(ClearIndex), 32'(i));
         tick();
      end
      Clear = 1'b0;
      check("clr2_done", 32'(Ready), 32'd1);
      AddressA = 6'd10; AddressB = 6'd11; #1;
      check("clr2_rd10", 32'(ReadDataA), 32'h0000);
      check("clr2_rd11", 32'(ReadDataB), 32'h0000);
      AddressA = 6'd5; AddressB = 6'd63; #1;
      check("clr2_rd5", 32'(ReadDataA), 32'h0000);
      check("clr2_rd63", 32'(ReadDataB), 32'h0000);

      // nReset mid-clear restarts the full sweep
      AddressA = 6'd20; WriteData = 16'h4321; WriteEnable = 1'b1; tick();
      WriteEnable = 1'b0; Clear = 1'b1; tick();
      Clear = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("mid_cidx", 32'(ClearIndex), 32'd20);
      nReset = 1'b0; #1;
      check("mid_rst_cidx", 32'(ClearIndex), 32'd0);
      check("mid_rst_ready", 32'(Ready), 32'd0);
      nReset = 1'b1;
      for (int i = 0; i < 64; i++) begin
         check("rst2_cidx", 32'(ClearIndex), 32'(i));
         check("rst2_ready", 32'(Ready), 32'd0);
         tick();
      end
      check("rst2_done", 32'(Ready), 32'd1);
      AddressA = 6'd20; #1;
      check("rst2_rd20", 32'(ReadDataA), 32'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
